// File: rtl/frac_baud_gen.sv
// ---------------------------------------------------------------------------
// frac_baud_gen
//   Fractional baud / SCLK generator. Runs on the system clock only. A
//   phase accumulator produces toggles whose average half-period is exactly
//   the programmed fixed-point divisor. A small start/stop FSM emits a
//   programmed number of edges (or free-runs until stopped). It holds clk_out
//   at the CPOL idle level while stopped, and it pulses tick on each edge and
//   done on normal completion.
//
//   Build option:
//     FRAC_BAUD_FRAC_EN  defined   -> full INT_W.FRAC_W accumulator
//                        undefined -> fractional divisor bits ignored,
//                                     half-period = floor(divisor), min 1
//
//   Ports:
//     clock       in   system clock, rising edge
//     reset       in   asynchronous active-low reset
//     enable      in   clock enable; low freezes accumulator/clk_out/count
//     divisor     in   half-period in clock cycles, UQ INT_W.FRAC_W
//     div_load    in   strobe: capture divisor into the pending shadow
//     start       in   begin a run (only honoured when idle)
//     stop        in   abort a run (wins over tick and start)
//     edge_count  in   toggles to produce, 0 = free-run
//     cpol        in   idle level of clk_out (latched at start)
//     clk_out     out  generated clock
//     tick        out  one-cycle pulse on every clk_out edge
//     busy        out  high while running
//     done        out  one-cycle pulse on normal completion
//     edges_left  out  remaining toggles (0 in free-run)
// ---------------------------------------------------------------------------
module frac_baud_gen #(
  parameter int INT_W  = 24,
  parameter int FRAC_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [INT_W+FRAC_W-1:0] divisor,
  input  logic                    div_load,
  input  logic                    start,
  input  logic                    stop,
  input  logic [CNT_W-1:0]        edge_count,
  input  logic                    cpol,
  output logic                    clk_out,
  output logic                    tick,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        edges_left
);

`ifdef FRAC_BAUD_FRAC_EN
  localparam int AF = FRAC_W;
`else
  localparam int AF = 0;
  // Fractional bits have no effect in the integer-only build.
  logic unused_frac_bits;
  assign unused_frac_bits = ^divisor[FRAC_W-1:0];
`endif

  // DW: divisor bits actually used; AW: accumulator gets one headroom bit
  // because acc + ONE can reach just under 2*D_act.
  localparam int DW = INT_W + AF;
  localparam int AW = DW + 1;
  localparam logic [DW-1:0] ONE = DW'(1) << AF;
  localparam logic [DW-1:0] TWO = ONE << 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state;
  logic [DW-1:0]   d_pend;
  logic [DW-1:0]   d_act;
  logic [AW-1:0]   acc;
  logic            cpol_q;

  logic [DW-1:0]   div_eff;
  logic [DW-1:0]   div_clamp;
  logic [AW-1:0]   acc_sum;
  logic [AW-1:0]   acc_wrap;
  logic            hit;

  // Top DW bits of the port: the whole value in the fractional build, only
  // the integer part otherwise.
  assign div_eff   = divisor[INT_W+FRAC_W-1 -: DW];
  // Anything below one cycle degenerates to a tick every enabled cycle.
  assign div_clamp = (div_eff < ONE) ? ONE : div_eff;

  assign acc_sum   = acc + AW'(ONE);
  assign hit       = (acc_sum >= {1'b0, d_act});
  assign acc_wrap  = acc_sum - {1'b0, d_act};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      d_pend     <= TWO;
      d_act      <= TWO;
      acc        <= '0;
      cpol_q     <= 1'b0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      edges_left <= '0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;

      // Shadow capture is independent of state; d_act only picks it up on
      // an edge boundary, so a load landing on a tick waits one more edge.
      if (div_load) d_pend <= div_clamp;

      case (state)
        S_IDLE: begin
          clk_out <= cpol;
          acc     <= '0;
          busy    <= 1'b0;
          if (start && !stop) begin
            state      <= S_RUN;
            busy       <= 1'b1;
            edges_left <= edge_count;
            d_act      <= d_pend;
            cpol_q     <= cpol;
          end
        end

        S_RUN: begin
          if (stop) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            clk_out <= cpol_q;
            acc     <= '0;
          end else if (enable) begin
            if (hit) begin
              tick  <= 1'b1;
              acc   <= acc_wrap;
              d_act <= d_pend;
              if (edges_left == CNT_W'(1)) begin
                // Last edge: land on idle level even for odd counts.
                clk_out    <= cpol_q;
                edges_left <= '0;
                done       <= 1'b1;
                busy       <= 1'b0;
                state      <= S_IDLE;
              end else begin
                clk_out <= ~clk_out;
                // edges_left==0 here means free-run; leave it at 0.
                if (edges_left != '0) edges_left <= edges_left - CNT_W'(1);
              end
            end else begin
              acc <= acc_sum;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/frac_baud_gen.md
# frac_baud_gen

Parametrised fractional baud/clock generator, successor to the integer divide-by-N divider in the SPI/GPIO subsystem. It runs entirely on the system clock with a synchronous clock-enable; there is no gated source clock. A true phase accumulator gives exact average half-periods with fractional divisors. A start/stop state machine emits a programmed number of SCLK edges (or free-runs), with CPOL idle level, a per-edge tick strobe and a completion pulse for the SPI shifter.

## Interface
- INT_W, 24, integer bits of the divisor
- FRAC_W, 8, fractional bits of the divisor (UQ INT_W.FRAC_W, ONE = 1<<FRAC_W)
- CNT_W, 16, edge-counter width

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  synchronous count enable; low freezes the accumulator
- divisor  in  INT_W+FRAC_W  half-period in clock cycles (fixed point)
- div_load  in  1  one-cycle strobe: capture divisor into pending shadow
- start  in  1  begin a run (sampled in IDLE only)
- stop  in  1  abort run
- edge_count  in  CNT_W  toggles to produce; 0 = free-run
- cpol  in  1  idle level of clk_out
- clk_out  out  1  generated clock
- tick  out  1  one-cycle pulse on every clk_out toggle
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on normal completion
- edges_left  out  CNT_W  remaining toggles (0 in free-run)

## Operation
- Registers: D_pend (shadow), D_act (in use), acc (INT_W+FRAC_W+1 bits), edges_left, state.
- div_load: D_pend <= divisor, any state. D_act <= D_pend at start and at every tick (glitch-free retune on edge boundaries). A load coincident with a tick takes effect at the next tick.
- Clamp: D_pend < ONE is treated as ONE (tick every enabled cycle).
- IDLE: clk_out <= cpol each cycle, acc held at 0, busy=0. start && !stop -> RUN; acc <= 0, edges_left <= edge_count, D_act <= D_pend, busy <= 1.
- RUN, enable=1: s = acc + ONE. If s >= D_act, then tick <= 1, clk_out <= ~clk_out, acc <= s - D_act. Otherwise acc <= s.
- RUN, enable=0: acc, clk_out and edges_left hold; tick=0.
- Counted mode: each tick decrements edges_left. On the tick where edges_left==1: clk_out <= cpol (odd counts are forced back to idle level), done <= 1, state -> IDLE, busy <= 0.
- Free-run (edge_count==0): runs until stop; edges_left stays 0.
- stop in RUN: -> IDLE next edge, clk_out <= cpol, tick=0, no done. stop has priority over a coincident tick and over start.
- start while RUN: ignored. cpol change during RUN: ignored until IDLE.

## Timing
- Reset values: clk_out=0, tick=0, busy=0, done=0, edges_left=0, state=IDLE, acc=0, D_pend=D_act=2·ONE. After reset release, clk_out follows cpol within 1 cycle.
- All outputs are registered. tick, clk_out toggle, done, busy fall and edges_left update share the same edge.
- start sampled at edge 0, enable=1, D=2.0: toggles at edges 2, 4, 6, …
- D = 2.5: toggles at edges 3, 5, 8, 10, … (gaps alternate 3, 2). Average is exactly D; instantaneous half-period is floor(D) or ceil(D).
- Max accumulator excursion < 2·D_act; no wrap for any divisor within range.

## Configuration
- FRAC_BAUD_FRAC_EN defined: full fractional accumulator as above.
- Undefined: divisor fractional bits are ignored (treated as 0) and the accumulator has INT_W+1 bits. Half-period is exactly floor(divisor) (min 1). Port widths are unchanged.

## Test plan
- Reset low mid-run with clk_out=1 and busy=1 -> all outputs 0 immediately; after release with cpol=1, clk_out=1 next edge.
- divisor=2.0, edge_count=8, cpol=0, enable=1, start -> toggles at edges 2..16, clk_out ends 0, done pulse at edge 16, busy low from edge 16.
- divisor=2.5 (FRAC_EN), free-run, 1000 cycles -> 400 ticks ±1, gaps only 2 or 3; without FRAC_EN -> gaps all 2.
- divisor=4.0, enable toggled 1/0 alternately -> toggles every 8 clocks; stop asserted -> clk_out=cpol next edge, no done.
- div_load 3.0 mid-run at D=2.0 -> current half-period finishes at 2, subsequent at 3; divisor=0 -> tick every enabled cycle.
- edge_count=3, cpol=1 -> toggles 0,1,then forced 1; done once; start and stop together in IDLE -> stays IDLE.
